// File: rtl/sdram_pkg.sv
// Shared constants for the W9864G6JT command engine: pin-level command encodings,
// engine state encoding and the fixed {bank,row,col} request address layout.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESELECT     = 4'b1111;
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_READ         = 4'b0101;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

    localparam int BANK_W   = 2;
    localparam int ROW_W    = 12;
    localparam int COL_W    = 8;
    localparam int ADDR_W   = BANK_W + ROW_W + COL_W;
    localparam int DATA_W   = 16;
    localparam int COL_LSB  = 0;
    localparam int ROW_LSB  = COL_W;
    localparam int BANK_LSB = COL_W + ROW_W;
    localparam int AP_BIT   = 10;

    typedef enum logic [2:0] {
        INIT_S,
        IDLE_S,
        REFRESH_S,
        ACT_S,
        RW_S,
        WAIT_S
    } state_t;

    function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] a);
        return a[BANK_LSB +: BANK_W];
    endfunction

    function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] a);
        return a[ROW_LSB +: ROW_W];
    endfunction

    function automatic logic [COL_W-1:0] addr_col(input logic [ADDR_W-1:0] a);
        return a[COL_LSB +: COL_W];
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter; raises a sticky pending flag on every wrap
// until the engine acknowledges by issuing AUTO REFRESH.
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int REF_PERIOD = 2500
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_en,
    input  logic i_ack,
    output logic o_pend
);

    localparam int CW = $clog2(REF_PERIOD);

    logic [CW-1:0] r_cnt;
    logic          r_pend;
    logic          w_wrap;

    assign w_wrap = i_en && (r_cnt == CW'(REF_PERIOD - 1));
    assign o_pend = r_pend;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (!i_en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A wrap landing on the ack cycle must not be lost, so set beats clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= 1'b0;
        end else if (!i_en) begin
            r_pend <= 1'b0;
        end else if (w_wrap) begin
            r_pend <= 1'b1;
        end else if (i_ack) begin
            r_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_cmd_engine.sv
// Post-init SDRAM command engine: mirrors the init sequencer until init_done_i, then
// serves one single-word auto-precharge read/write at a time and periodic AUTO REFRESH.
module sdram_cmd_engine
    import sdram_pkg::*;
#(
    parameter int CAS_LATENCY = 2,
    parameter int TRCD        = 3,
    parameter int TRP         = 3,
    parameter int TRC         = 10,
    parameter int TWR         = 2,
    parameter int REF_PERIOD  = 2500
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              init_done_i,
    input  logic [11:0]       init_a_i,
    input  logic [1:0]        init_bs_i,
    input  logic [3:0]        init_cmd_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [21:0]       cmd_addr_i,
    input  logic [15:0]       cmd_wdata_i,
    output logic              rd_valid_o,
    output logic [15:0]       rd_data_o,
    output logic [11:0]       sdram_a_o,
    output logic [1:0]        sdram_bs_o,
    output logic [3:0]        sdram_cmd_o,
    output logic [1:0]        sdram_dqm_o,
    output logic [15:0]       sdram_dq_o,
    output logic              sdram_dq_oe_o,
    input  logic [15:0]       sdram_dq_i
);

    localparam int ROW_CYCLES = max_int(TRC, max_int(TRCD + 1 + TWR + TRP, TRCD + CAS_LATENCY + 2));
    localparam int CNT_W      = $clog2(ROW_CYCLES + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_ref_pend;
    logic                w_ref_ack;
    logic                w_accept;

    logic [3:0]          w_cmd;
    logic [11:0]         w_a;
    logic [1:0]          w_bs;
    logic [1:0]          w_dqm;
    logic [DATA_W-1:0]   w_dq;
    logic                w_dq_oe;
    logic                w_rd_issue;

    logic [CAS_LATENCY:0] r_rd_pipe;

    assign cmd_ready_o = (r_state == IDLE_S) && !w_ref_pend;
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_ref_ack   = (r_state == REFRESH_S) && (r_cnt == '0);

    sdram_refresh_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_en   (r_state != INIT_S),
        .i_ack  (w_ref_ack),
        .o_pend (w_ref_pend)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= INIT_S;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= cmd_we_i;
            r_addr  <= cmd_addr_i;
            r_wdata <= cmd_wdata_i;
        end
    end

    // Pins are registered, so each state's command shows up one clock later. Returning
    // to IDLE_S one clock early lets the next ACTIVE/REFRESH land exactly on the slot boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_cmd       = CMD_NOP;
        w_a         = '0;
        w_bs        = '0;
        w_dqm       = 2'b11;
        w_dq        = '0;
        w_dq_oe     = 1'b0;
        w_rd_issue  = 1'b0;
        unique case (r_state)
            INIT_S: begin
                w_cmd     = init_cmd_i;
                w_a       = init_a_i;
                w_bs      = init_bs_i;
                w_cnt_nxt = '0;
                if (init_done_i) begin
                    w_state_nxt = IDLE_S;
                end
            end
            IDLE_S: begin
                w_cnt_nxt = '0;
                if (w_ref_pend) begin
                    w_state_nxt = REFRESH_S;
                end else if (cmd_valid_i) begin
                    w_state_nxt = ACT_S;
                end
            end
            REFRESH_S: begin
                if (r_cnt == '0) begin
                    w_cmd = CMD_AUTO_REFRESH;
                end
                if (r_cnt == CNT_W'(TRC - 2)) begin
                    w_state_nxt = IDLE_S;
                end
            end
            ACT_S: begin
                if (r_cnt == '0) begin
                    w_cmd = CMD_ACTIVE;
                    w_bs  = addr_bank(r_addr);
                    w_a   = addr_row(r_addr);
                end
                if (r_cnt == CNT_W'(TRCD - 1)) begin
                    w_state_nxt = RW_S;
                end
            end
            RW_S: begin
                w_cmd            = r_we ? CMD_WRITE : CMD_READ;
                w_bs             = addr_bank(r_addr);
                w_a[COL_W-1:0]   = addr_col(r_addr);
                w_a[AP_BIT]      = 1'b1;
                w_dqm            = 2'b00;
                w_dq             = r_we ? r_wdata : '0;
                w_dq_oe          = r_we;
                w_rd_issue       = !r_we;
                w_state_nxt      = WAIT_S;
            end
            WAIT_S: begin
                if (r_cnt == CNT_W'(ROW_CYCLES - 2)) begin
                    w_state_nxt = IDLE_S;
                end
            end
            default: begin
                w_state_nxt = INIT_S;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sdram_cmd_o   <= CMD_DESELECT;
            sdram_a_o     <= '0;
            sdram_bs_o    <= '0;
            sdram_dqm_o   <= 2'b11;
            sdram_dq_o    <= '0;
            sdram_dq_oe_o <= 1'b0;
        end else begin
            sdram_cmd_o   <= w_cmd;
            sdram_a_o     <= w_a;
            sdram_bs_o    <= w_bs;
            sdram_dqm_o   <= w_dqm;
            sdram_dq_o    <= w_dq;
            sdram_dq_oe_o <= w_dq_oe;
        end
    end

    // Bit 0 rises with READ on the pins; bit CAS_LATENCY marks the clock dq_i holds the word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_pipe  <= '0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            r_rd_pipe  <= {r_rd_pipe[CAS_LATENCY-1:0], w_rd_issue};
            rd_valid_o <= r_rd_pipe[CAS_LATENCY];
            if (r_rd_pipe[CAS_LATENCY]) begin
                rd_data_o <= sdram_dq_i;
            end
        end
    end

endmodule
